alu_req_arbiter: RTL

//  Shares the single combinational 4-bit ALU between two requesters (e.g. control FSM and debug port).

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_req_arbiter_rr_arbiter2.sv | 20 ++
 rtl/alu_req_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared ALU opcodes, arbiter FSM states and default widths.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int WIDTH   = 4;
  localparam int OPW     = 4;
  localparam int FLAGW   = 5;
  localparam int CNTW    = 8;
  localparam int OP_LAST = 9;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MUL = 4'd2,
    DIV = 4'd3,
    MOD = 4'd4,
    AND = 4'd5,
    OR  = 4'd6,
    NOR = 4'd7,
    SHL = 4'd8,
    SHR = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_req_arbiter_rr_arbiter2.sv
// ============================================================================
// Module : rr_arbiter2
// Brief  : Two-way round-robin grant; the non-last requester wins a tie.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  assign grant_valid = |valid;
  assign grant       = (valid == 2'b11) ? ~last_grant : valid[1];

endmodule

`default_nettype wire

// File: rtl/alu_req_arbiter.sv
// ============================================================================
// Module : alu_req_arbiter
// Brief  : Shares one combinational ALU between two requesters, one op in
//          flight, registered issue and registered result/flags response.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int OPW   = alu_pkg::OPW,
  parameter int FLAGW = alu_pkg::FLAGW,
  parameter int CNTW  = alu_pkg::CNTW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_q,
  output logic [FLAGW-1:0] rsp_flags,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_s,
  input  logic [WIDTH-1:0] alu_q,
  input  logic [FLAGW-1:0] alu_f,
  output logic [CNTW-1:0]  op_count
);

  arb_state_e       r_state;
  logic             r_owner;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_q;
  logic [FLAGW-1:0] r_flags;
  logic             r_err;
  logic [CNTW-1:0]  r_op_count;

  logic             w_grant;
  logic             w_grant_valid;
  logic             w_accept;
  logic             w_rsp_ready;
  logic             w_op_illegal;

  rr_arbiter2 u_rr_arbiter2 (
    .valid       ({req1_valid, req0_valid}),
    .last_grant  (r_last_grant),
    .grant       (w_grant),
    .grant_valid (w_grant_valid)
  );

  // Ready is gated by rst so every output reads 0 while reset is held.
  assign w_accept     = !rst && (r_state == IDLE) && w_grant_valid;
  assign req0_ready   = w_accept && !w_grant;
  assign req1_ready   = w_accept &&  w_grant;

  assign w_rsp_ready  = r_owner ? rsp1_ready : rsp0_ready;
  assign w_op_illegal = (r_op > OPW'(OP_LAST));

  assign rsp0_valid   = (r_state == RESP) && !r_owner;
  assign rsp1_valid   = (r_state == RESP) &&  r_owner;
  assign rsp_q        = r_q;
  assign rsp_flags    = r_flags;
  assign rsp_err      = r_err;
  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign alu_s        = r_op;
  assign op_count     = r_op_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_q          <= '0;
      r_flags      <= '0;
      r_err        <= 1'b0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner <= w_grant;
            r_a     <= w_grant ? req1_a  : req0_a;
            r_b     <= w_grant ? req1_b  : req0_b;
            r_op    <= w_grant ? req1_op : req0_op;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          // Illegal selectors return a clean zero result instead of ALU output.
          if (w_op_illegal) begin
            r_q     <= '0;
            r_flags <= '0;
            r_err   <= 1'b1;
          end else begin
            r_q     <= alu_q;
            r_flags <= alu_f;
            r_err   <= 1'b0;
          end
          r_state <= RESP;
        end
        RESP: begin
          if (w_rsp_ready) begin
            r_last_grant <= r_owner;
            r_op_count   <= r_op_count + CNTW'(1);
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
